// File: rtl/gs_i2s_tx.sv
// rtl/gs_i2s_tx.sv - I2S serialiser for the General Sound L/R outputs, BCLK/LRCK from clk_sys enables.
// Optional feature macro: GS_I2S_ATTEN_EN (adds 3-bit atten port, arithmetic right shift at latch).
module gs_i2s_tx #(
    parameter int BCLK_DIV  = 28,
    parameter int SLOT_BITS = 32
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
`ifdef GS_I2S_ATTEN_EN
    input  logic [2:0]  atten,
`endif
    output logic        sample_strobe,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_data
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = $clog2(BCLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_BITS);

    // S_ARM: next fall event starts a fresh frame at bit 0 instead of advancing.
    typedef enum logic {S_ARM, S_RUN} state_t;
    state_t state, state_nxt;

    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt, pos;
    logic [15:0]      shadow_l, shadow_r, cap_l, cap_r, sample;
    logic [3:0]       msb_off;
    logic             fall, latch, slot_nxt, data_nxt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= S_ARM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = S_ARM;
        end else if (fall) begin
            state_nxt = S_RUN;
        end
    end

    always_comb begin
        fall     = en && (div_cnt == DIV_LAST);
        div_nxt  = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        bit_nxt  = (state == S_ARM || bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        latch    = fall && (bit_nxt == '0);
        slot_nxt = (bit_nxt >= SLOT_N);
        pos      = slot_nxt ? bit_nxt - SLOT_N : bit_nxt;
        sample   = slot_nxt ? shadow_r : shadow_l;
        msb_off  = 4'(BIT_W'(16) - pos);
        // MSB goes out one bit after the LRCK edge; zero padding after the LSB.
        data_nxt = (pos >= BIT_W'(1) && pos <= BIT_W'(16)) ? sample[msb_off] : 1'b0;
`ifdef GS_I2S_ATTEN_EN
        cap_l    = 16'($signed(in_l) >>> atten);
        cap_r    = 16'($signed(in_r) >>> atten);
`else
        cap_l    = in_l;
        cap_r    = in_r;
`endif
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_cnt       <= '0;
            bit_cnt       <= '0;
            shadow_l      <= '0;
            shadow_r      <= '0;
            sample_strobe <= 1'b0;
            i2s_bclk      <= 1'b0;
            i2s_lrck      <= 1'b0;
            i2s_data      <= 1'b0;
        end else if (!en) begin
            div_cnt       <= '0;
            bit_cnt       <= '0;
            sample_strobe <= 1'b0;
            i2s_bclk      <= 1'b0;
            i2s_lrck      <= 1'b0;
            i2s_data      <= 1'b0;
        end else begin
            div_cnt       <= div_nxt;
            i2s_bclk      <= (div_nxt >= DIV_HALF);
            sample_strobe <= latch;
            if (fall) begin
                bit_cnt  <= bit_nxt;
                i2s_lrck <= slot_nxt;
                i2s_data <= data_nxt;
            end
            if (latch) begin
                shadow_l <= cap_l;
                shadow_r <= cap_r;
            end
        end
    end
endmodule

// File: tb/tb_gs_i2s_tx.sv
// tb/tb_gs_i2s_tx.sv - Randomised self-checking bench for gs_i2s_tx against an elapsed-time frame model.
module tb_gs_i2s_tx;
    localparam int DIV   = 28;
    localparam int SLOT  = 32;
    localparam int FRAME = 64;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        en      = 1'b0;
    logic [15:0] in_l    = '0;
    logic [15:0] in_r    = '0;
`ifdef GS_I2S_ATTEN_EN
    logic [2:0]  atten   = '0;
`endif
    logic        sample_strobe, i2s_bclk, i2s_lrck, i2s_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    gs_i2s_tx #(.BCLK_DIV(DIV), .SLOT_BITS(SLOT)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .en            (en),
        .in_l          (in_l),
        .in_r          (in_r),
`ifdef GS_I2S_ATTEN_EN
        .atten         (atten),
`endif
        .sample_strobe (sample_strobe),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrck      (i2s_lrck),
        .i2s_data      (i2s_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] shape(input logic [15:0] x);
`ifdef GS_I2S_ATTEN_EN
        return 16'($signed(x) >>> atten);
`else
        return x;
`endif
    endfunction

    // t = enabled clk_sys edges since reset / enable; every DIV-th edge is a BCLK fall.
    function automatic bit is_latch(input int t);
        return (t > 0) && (t % DIV == 0) && (((t / DIV - 1) % FRAME) == 0);
    endfunction

    function automatic logic [3:0] expect_out(input int t, input logic [15:0] l, input logic [15:0] r);
        int f, b, p;
        logic [15:0] s;
        logic d, lr;
        d  = 1'b0;
        lr = 1'b0;
        f  = t / DIV;
        if (f > 0) begin
            b  = (f - 1) % FRAME;
            lr = (b >= SLOT);
            p  = b % SLOT;
            s  = lr ? r : l;
            if (p >= 1 && p <= 16) d = s[16 - p];
        end
        return {is_latch(t), ((t % DIV) >= DIV / 2), lr, d};
    endfunction

    int          m_t = 0;
    logic [15:0] m_l = '0;
    logic [15:0] m_r = '0;

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_t <= 0;
            m_l <= '0;
            m_r <= '0;
        end else if (!en) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
            if (is_latch(m_t + 1)) begin
                m_l <= shape(in_l);
                m_r <= shape(in_r);
            end
        end
    end

    always @(negedge clk_sys) begin
        #1;
        check("outputs", 64'({sample_strobe, i2s_bclk, i2s_lrck, i2s_data}),
              64'(expect_out(m_t, m_l, m_r)));
    end

    task automatic wait_strobe(output int n);
        n = 0;
        forever begin
            @(negedge clk_sys);
            n++;
            if (sample_strobe) return;
            if (n > 4000) begin
                n_cmp++;
                n_err++;
                $display("FAIL strobe_timeout: no sample_strobe within %0d cycles", n);
                return;
            end
        end
    endtask

    // Called at a strobe negedge; collects bits first..first+count-1 at mid-bit.
    task automatic capture(input int first, input int count, output logic [63:0] w);
        int off;
        off = 0;
        w   = '0;
        for (int j = 0; j < first + count; j++) begin
            repeat (DIV * j + DIV / 2 - off) @(negedge clk_sys);
            off = DIV * j + DIV / 2;
            if (j >= first) w = {w[62:0], i2s_data};
        end
    endtask

    initial begin
        int          n, hi, lr_hi, rises, bad_edges;
        logic [63:0] w, frame;
        logic        p_bclk, p_lr, p_d;

        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        en    = 1'b1;
        in_l  = 16'hA5C3;
        in_r  = 16'h3C5A;
        wait_strobe(n);
        check("first_strobe_latency", 64'(n), 64'd28);

        hi = 0; lr_hi = 0; rises = 0; bad_edges = 0; frame = '0;
        p_bclk = i2s_bclk; p_lr = i2s_lrck; p_d = i2s_data;
        for (int c = 0; c < DIV * FRAME; c++) begin
            if (c % DIV == DIV / 2) frame = {frame[62:0], i2s_data};
            hi    += int'(i2s_bclk);
            lr_hi += int'(i2s_lrck);
            if (i2s_bclk && !p_bclk) rises++;
            if (c > 0 && (i2s_lrck != p_lr || i2s_data != p_d) && !(p_bclk && !i2s_bclk)) bad_edges++;
            p_bclk = i2s_bclk; p_lr = i2s_lrck; p_d = i2s_data;
            @(negedge clk_sys);
        end
        check("frame_bits", frame, {1'b0, 16'hA5C3, 15'h0, 1'b0, 16'h3C5A, 15'h0});
        check("bclk_high_cycles", 64'(hi), 64'd896);
        check("bclk_periods", 64'(rises), 64'd64);
        check("lrck_high_cycles", 64'(lr_hi), 64'd896);
        check("edges_off_bclk_fall", 64'(bad_edges), 64'd0);
        check("strobe_period_1792", 64'(sample_strobe), 64'd1);

        in_l = 16'h1234;
        wait_strobe(n);
        capture(1, 16, w);
        check("left_before_change", w, 64'h1234);
        in_l = 16'hFFFF;
        wait_strobe(n);
        check("strobe_after_change", 64'(n), 64'(DIV * FRAME - DIV * 16 - DIV / 2));
        capture(1, 16, w);
        check("left_after_change", w, 64'hFFFF);

        wait_strobe(n);
        repeat (DIV * 40 + 5) @(negedge clk_sys);
        en = 1'b0;
        @(negedge clk_sys);
        check("en_off_outputs", 64'({sample_strobe, i2s_bclk, i2s_lrck, i2s_data}), 64'd0);
        n = 0;
        repeat (100) begin
            @(negedge clk_sys);
            n += int'(sample_strobe);
        end
        check("no_strobe_while_off", 64'(n), 64'd0);
        en = 1'b1;
        wait_strobe(n);
        check("reenable_latency", 64'(n), 64'd28);
        check("reenable_lrck", 64'(i2s_lrck), 64'd0);

        wait_strobe(n);
        repeat (DIV * 45 + 3) @(negedge clk_sys);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 64'({sample_strobe, i2s_bclk, i2s_lrck, i2s_data}), 64'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        wait_strobe(n);
        check("post_reset_latency", 64'(n), 64'd28);

`ifdef GS_I2S_ATTEN_EN
        in_l  = 16'h8000;
        atten = 3'd3;
        wait_strobe(n);
        capture(1, 16, w);
        check("atten3_left", w, 64'hF000);
        atten = 3'd0;
        in_l  = 16'h7FFF;
        wait_strobe(n);
        capture(1, 16, w);
        check("atten0_left", w, 64'h7FFF);
`endif

        for (int c = 0; c < 15000; c++) begin
            @(negedge clk_sys);
            if ($urandom_range(0, 63) == 0) in_l = 16'($urandom);
            if ($urandom_range(0, 63) == 0) in_r = 16'($urandom);
            if ($urandom_range(0, 2999) == 0) en = ~en;
`ifdef GS_I2S_ATTEN_EN
            if ($urandom_range(0, 255) == 0) atten = 3'($urandom);
`endif
        end

        @(negedge clk_sys);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
